// File: rtl/cipu_pkg.sv
// Shared types and default codes for the CIPU stream engine.
// Both channel FSM encodings live here so sub-blocks agree on them.
package cipu_pkg;

    localparam logic [7:0] CIPU_TERM = 8'h24;
    localparam logic [7:0] CIPU_SEP  = 8'h3B;
    localparam logic [7:0] CIPU_LO   = 8'h41;
    localparam logic [7:0] CIPU_HI   = 8'h5A;

    typedef enum logic [1:0] {
        P_IDLE,
        P_COLLECT,
        P_REPLAY,
        P_DONE
    } people_st_e;

    typedef enum logic [2:0] {
        T_IDLE,
        T_PUSH,
        T_POP,
        T_ACK,
        T_DRAIN,
        T_DONE
    } thing_st_e;

endpackage

// File: rtl/cipu_stream_engine_if.sv
// Character stream bundle between a source/sink and the engine.
// master drives the character inputs, slave is the engine side.
interface cipu_stream_engine_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);

    logic [DATA_W-1:0] people_thing_in;
    logic              ready_fifo;
    logic              ready_lifo;
    logic [DATA_W-1:0] thing_in;
    logic [CNT_W-1:0]  thing_num;
    logic              valid_fifo;
    logic              valid_lifo;
    logic              valid_fifo2;
    logic [DATA_W-1:0] people_thing_out;
    logic [DATA_W-1:0] thing_out;
    logic              done_thing;
    logic              done_fifo;
    logic              done_lifo;
    logic              done_fifo2;
    logic              ovf_people;
    logic              ovf_thing;
    logic              unf_thing;

    modport master (
        output people_thing_in, ready_fifo, ready_lifo,
        output thing_in, thing_num,
        input  valid_fifo, valid_lifo, valid_fifo2,
        input  people_thing_out, thing_out,
        input  done_thing, done_fifo, done_lifo, done_fifo2,
        input  ovf_people, ovf_thing, unf_thing
    );

    modport slave (
        input  people_thing_in, ready_fifo, ready_lifo,
        input  thing_in, thing_num,
        output valid_fifo, valid_lifo, valid_fifo2,
        output people_thing_out, thing_out,
        output done_thing, done_fifo, done_lifo, done_fifo2,
        output ovf_people, ovf_thing, unf_thing
    );

endinterface

// File: rtl/cipu_dual_stack.sv
// Storage array readable from the top (LIFO pop) or from the bottom
// (FIFO-style drain); live items occupy [bot, top).
module cipu_dual_stack #(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 16,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    input  logic              rd,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CW-1:0]     top_q, top_d;
    logic [CW-1:0]     bot_q, bot_d;
    logic [CW-1:0]     top_m1;
    logic              push_ok, pop_ok, rd_ok;

    assign full    = (top_q == CW'(DEPTH));
    assign empty   = (top_q == bot_q);
    assign count   = top_q - bot_q;
    assign top_m1  = top_q - CW'(1);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_ok   = rd & ~empty;

    assign pop_data = mem_q[top_m1[AW-1:0]];
    assign rd_data  = mem_q[bot_q[AW-1:0]];

    always_comb begin
        top_d = top_q;
        bot_d = bot_q;
        if (push_ok) begin
            top_d = top_q + CW'(1);
        end else if (pop_ok) begin
            top_d = top_m1;
        end else if (rd_ok) begin
            // reading the last item rewinds both pointers
            if (bot_q + CW'(1) == top_q) begin
                top_d = '0;
                bot_d = '0;
            end else begin
                bot_d = bot_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q <= '0;
            bot_q <= '0;
        end else begin
            top_q <= top_d;
            bot_q <= bot_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[top_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cipu_stream_engine.sv
// Two-channel passenger/cargo stream engine: people replay in arrival
// order, cargo pops top-first per separator and drains bottom-first.
module cipu_stream_engine
    import cipu_pkg::*;
#(
    parameter int              DATA_W       = 8,
    parameter int              PEOPLE_DEPTH = 16,
    parameter int              THING_DEPTH  = 32,
    parameter int              CNT_W        = 4,
    parameter logic [DATA_W-1:0] TERM       = DATA_W'(CIPU_TERM),
    parameter logic [DATA_W-1:0] SEP        = DATA_W'(CIPU_SEP),
    parameter logic [DATA_W-1:0] LO_CHAR    = DATA_W'(CIPU_LO),
    parameter logic [DATA_W-1:0] HI_CHAR    = DATA_W'(CIPU_HI)
) (
    input logic                 clk,
    input logic                 rst,
    cipu_stream_engine_if.slave io
);

    localparam int PCW   = $clog2(PEOPLE_DEPTH + 1);
    localparam int TCW   = $clog2(THING_DEPTH + 1);
    localparam int CMP_W = (TCW > CNT_W) ? TCW : CNT_W;

    people_st_e        p_st_q, p_st_d;
    logic              valid_fifo_q, valid_fifo_d;
    logic [DATA_W-1:0] pout_q, pout_d;
    logic              done_fifo_q, done_fifo_d;
    logic              ovf_people_q, ovf_people_d;
    logic              p_push, p_rd, p_full, p_empty;
    logic [DATA_W-1:0] p_rd_data, p_pop_data;
    logic [PCW-1:0]    p_count;
    logic              p_unused;

    assign p_unused = ^{p_pop_data, p_count};

    cipu_dual_stack #(
        .DATA_W(DATA_W),
        .DEPTH (PEOPLE_DEPTH)
    ) u_people (
        .clk      (clk),
        .rst      (rst),
        .push     (p_push),
        .push_data(io.people_thing_in),
        .pop      (1'b0),
        .pop_data (p_pop_data),
        .rd       (p_rd),
        .rd_data  (p_rd_data),
        .full     (p_full),
        .empty    (p_empty),
        .count    (p_count)
    );

    always_comb begin
        p_st_d       = p_st_q;
        valid_fifo_d = 1'b0;
        pout_d       = pout_q;
        done_fifo_d  = done_fifo_q;
        ovf_people_d = ovf_people_q;
        p_push       = 1'b0;
        p_rd         = 1'b0;
        unique case (p_st_q)
            P_IDLE: begin
                if (io.ready_fifo) p_st_d = P_COLLECT;
            end
            P_COLLECT: begin
                if (io.people_thing_in == TERM) begin
                    p_st_d = P_REPLAY;
                end else if (io.people_thing_in >= LO_CHAR &&
                             io.people_thing_in <= HI_CHAR) begin
                    if (p_full) ovf_people_d = 1'b1;
                    else        p_push       = 1'b1;
                end
            end
            P_REPLAY: begin
                if (!p_empty) begin
                    p_rd         = 1'b1;
                    valid_fifo_d = 1'b1;
                    pout_d       = p_rd_data;
                end else begin
                    done_fifo_d = 1'b1;
                    p_st_d      = P_DONE;
                end
            end
            P_DONE: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_st_q       <= P_IDLE;
            valid_fifo_q <= 1'b0;
            pout_q       <= '0;
            done_fifo_q  <= 1'b0;
            ovf_people_q <= 1'b0;
        end else begin
            p_st_q       <= p_st_d;
            valid_fifo_q <= valid_fifo_d;
            pout_q       <= pout_d;
            done_fifo_q  <= done_fifo_d;
            ovf_people_q <= ovf_people_d;
        end
    end

    thing_st_e         t_st_q, t_st_d;
    logic [CNT_W-1:0]  pcnt_q, pcnt_d;
    logic              valid_lifo_q, valid_lifo_d;
    logic              valid_fifo2_q, valid_fifo2_d;
    logic [DATA_W-1:0] tout_q, tout_d;
    logic              done_thing_q, done_thing_d;
    logic              done_lifo_q, done_lifo_d;
    logic              done_fifo2_q, done_fifo2_d;
    logic              ovf_thing_q, ovf_thing_d;
    logic              unf_thing_q, unf_thing_d;
    logic              t_push, t_pop, t_rd, t_full, t_empty;
    logic [DATA_W-1:0] t_pop_data, t_rd_data;
    logic [TCW-1:0]    t_count;
    logic [CMP_W-1:0]  num_ext, cnt_ext, k_ext;

    assign num_ext = CMP_W'(io.thing_num);
    assign cnt_ext = CMP_W'(t_count);
    assign k_ext   = (num_ext > cnt_ext) ? cnt_ext : num_ext;

    cipu_dual_stack #(
        .DATA_W(DATA_W),
        .DEPTH (THING_DEPTH)
    ) u_thing (
        .clk      (clk),
        .rst      (rst),
        .push     (t_push),
        .push_data(io.thing_in),
        .pop      (t_pop),
        .pop_data (t_pop_data),
        .rd       (t_rd),
        .rd_data  (t_rd_data),
        .full     (t_full),
        .empty    (t_empty),
        .count    (t_count)
    );

    always_comb begin
        t_st_d        = t_st_q;
        pcnt_d        = pcnt_q;
        valid_lifo_d  = 1'b0;
        valid_fifo2_d = 1'b0;
        tout_d        = tout_q;
        done_thing_d  = 1'b0;
        done_lifo_d   = done_lifo_q;
        done_fifo2_d  = done_fifo2_q;
        ovf_thing_d   = ovf_thing_q;
        unf_thing_d   = unf_thing_q;
        t_push        = 1'b0;
        t_pop         = 1'b0;
        t_rd          = 1'b0;
        unique case (t_st_q)
            T_IDLE: begin
                if (io.ready_lifo) t_st_d = T_PUSH;
            end
            T_PUSH: begin
                if (io.thing_in == SEP) begin
                    if (num_ext > cnt_ext) unf_thing_d = 1'b1;
                    pcnt_d = CNT_W'(k_ext);
                    t_st_d = (k_ext == '0) ? T_ACK : T_POP;
                end else if (io.thing_in == TERM) begin
                    done_lifo_d = 1'b1;
                    t_st_d      = T_DRAIN;
                end else if (t_full) begin
                    ovf_thing_d = 1'b1;
                end else begin
                    t_push = 1'b1;
                end
            end
            T_POP: begin
                t_pop        = 1'b1;
                valid_lifo_d = 1'b1;
                tout_d       = t_pop_data;
                pcnt_d       = pcnt_q - CNT_W'(1);
                if (pcnt_q == CNT_W'(1)) t_st_d = T_ACK;
            end
            T_ACK: begin
                // the source swaps its token while this pulse is up
                done_thing_d = 1'b1;
                t_st_d       = T_PUSH;
            end
            T_DRAIN: begin
                if (!t_empty) begin
                    t_rd          = 1'b1;
                    valid_fifo2_d = 1'b1;
                    tout_d        = t_rd_data;
                end else begin
                    done_fifo2_d = 1'b1;
                    t_st_d       = T_DONE;
                end
            end
            T_DONE: ;
            default: t_st_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_st_q        <= T_IDLE;
            pcnt_q        <= '0;
            valid_lifo_q  <= 1'b0;
            valid_fifo2_q <= 1'b0;
            tout_q        <= '0;
            done_thing_q  <= 1'b0;
            done_lifo_q   <= 1'b0;
            done_fifo2_q  <= 1'b0;
            ovf_thing_q   <= 1'b0;
            unf_thing_q   <= 1'b0;
        end else begin
            t_st_q        <= t_st_d;
            pcnt_q        <= pcnt_d;
            valid_lifo_q  <= valid_lifo_d;
            valid_fifo2_q <= valid_fifo2_d;
            tout_q        <= tout_d;
            done_thing_q  <= done_thing_d;
            done_lifo_q   <= done_lifo_d;
            done_fifo2_q  <= done_fifo2_d;
            ovf_thing_q   <= ovf_thing_d;
            unf_thing_q   <= unf_thing_d;
        end
    end

    assign io.valid_fifo       = valid_fifo_q;
    assign io.people_thing_out = pout_q;
    assign io.done_fifo        = done_fifo_q;
    assign io.ovf_people       = ovf_people_q;
    assign io.valid_lifo       = valid_lifo_q;
    assign io.valid_fifo2      = valid_fifo2_q;
    assign io.thing_out        = tout_q;
    assign io.done_thing       = done_thing_q;
    assign io.done_lifo        = done_lifo_q;
    assign io.done_fifo2       = done_fifo2_q;
    assign io.ovf_thing        = ovf_thing_q;
    assign io.unf_thing        = unf_thing_q;

endmodule
